pipeline_rc_adder: RTL and testbench



---
 rtl/pipeline_rc_adder.sv | 126 ++++++++++++
 tb/tb_pipeline_rc_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_rc_adder.sv
// Pipelined ripple-carry adder: sum/cout = a + b + cin, split into STAGES equal ripple slices.
// Latency: operands sampled at edge t produce sum/cout after edge t+STAGES-1; one result per clock.
// Backpressure: none; a new operand set is accepted every cycle and the pipeline never stalls.
module pipeline_rc_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bits handled by each slice.
    localparam int W = WIDTH / STAGES;

    // Reject parameter sets that cannot be split into equal slices.
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipeline_rc_adder: WIDTH must be a positive multiple of STAGES");
    end

    // W-bit ripple-carry chain of full adders; returns {carry_out, partial_sum}.
    function automatic logic [W:0] rca_slice(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         c0
    );
        logic [W-1:0] s;
        logic         c;
        s = '0;
        c = c0;
        for (int i = 0; i < W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    // Stage k adds slice k. Operand bits still to be added travel right-aligned
    // (slice k+1 at bit 0) so every stage reads its slice from the bottom, and the
    // finished partial sums grow from the bottom as the deskew register.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-k*W-1:0] up_a;
        logic [WIDTH-k*W-1:0] up_b;
        logic                 c_in;
        logic [W:0]           slice_res;
        logic [(k+1)*W-1:0]   sum_d;
        logic [(k+1)*W-1:0]   sum_q;
        logic                 carry_d;
        logic                 carry_q;

        if (k == 0) begin : g_src
            // First stage reads the live operands and carry-in.
            always_comb begin
                up_a = a;
                up_b = b;
                c_in = cin;
            end

            // First slice starts the deskewed sum.
            always_comb begin
                sum_d = slice_res[W-1:0];
            end
        end else begin : g_src
            // Later stages read the operand bits and carry delayed by the previous stage.
            always_comb begin
                up_a = g_stage[k-1].g_ops.opa_q;
                up_b = g_stage[k-1].g_ops.opb_q;
                c_in = g_stage[k-1].carry_q;
            end

            // Append this slice above the lower partial sums of the same operand set.
            always_comb begin
                sum_d = {slice_res[W-1:0], g_stage[k-1].sum_q};
            end
        end

        // Ripple-add this stage's slice with the incoming carry.
        always_comb begin
            slice_res = rca_slice(up_a[W-1:0], up_b[W-1:0], c_in);
            carry_d   = slice_res[W];
        end

        // Partial sum and slice carry registers, cleared immediately by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-(k+1)*W-1:0] opa_d;
            logic [WIDTH-(k+1)*W-1:0] opa_q;
            logic [WIDTH-(k+1)*W-1:0] opb_d;
            logic [WIDTH-(k+1)*W-1:0] opb_q;

            // Drop the slice consumed here and forward the upper operand bits.
            always_comb begin
                opa_d = up_a[WIDTH-k*W-1:W];
                opb_d = up_b[WIDTH-k*W-1:W];
            end

            // Delayed upper operand bits, aligned with this stage's carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end
    end

    assign sum  = g_stage[STAGES-1].sum_q;
    assign cout = g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipeline_rc_adder.sv
`timescale 1ns/1ps
module tb_pipeline_rc_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;

    int checks   = 0;
    int failures = 0;

    pipeline_rc_adder #(.WIDTH(64), .STAGES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 65'd0) begin
            failures++;
            $display("FAIL reset_state: got cout=%b sum=%h want cout=0 sum=0", cout, sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        a = 64'd0; b = 64'd200; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 65'd0) begin
            failures++;
            $display("FAIL basic_early: got cout=%b sum=%h want 0 after 3 edges", cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if ({cout, sum} !== 65'd200) begin
            failures++;
            $display("FAIL basic_200: got cout=%b sum=%h want sum=c8", cout, sum);
        end
        cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 65'd200) begin
            failures++;
            $display("FAIL basic_cin_early: got cout=%b sum=%h want sum=c8", cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if ({cout, sum} !== 65'd201) begin
            failures++;
            $display("FAIL basic_201: got cout=%b sum=%h want sum=c9", cout, sum);
        end
    endtask

    task automatic test_boundary();
        logic [63:0] va [4];
        logic [63:0] vb [4];
        logic        vc [4];
        logic [64:0] ve [4];
        va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'd1; vc[0] = 1'b0; ve[0] = 65'h0_0000_0000_0001_0000;
        va[1] = 64'h0000_0000_FFFF_FFFF; vb[1] = 64'd1; vc[1] = 1'b0; ve[1] = 65'h0_0000_0001_0000_0000;
        va[2] = 64'h0000_FFFF_FFFF_FFFF; vb[2] = 64'd1; vc[2] = 1'b0; ve[2] = 65'h0_0001_0000_0000_0000;
        va[3] = 64'h0000_0000_0000_FFFF; vb[3] = 64'd0; vc[3] = 1'b1; ve[3] = 65'h0_0000_0000_0001_0000;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i];
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if ({cout, sum} !== ve[i]) begin
                failures++;
                $display("FAIL boundary_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                         i, cout, sum, ve[i][64], ve[i][63:0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] va [4];
        logic [63:0] vb [4];
        logic        vc [4];
        logic [64:0] ve [4];
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1;                  vc[0] = 1'b0; ve[0] = {1'b1, 64'h0};
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd0;                  vc[1] = 1'b1; ve[1] = {1'b1, 64'h0};
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF; vc[2] = 1'b1; ve[2] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000; vc[3] = 1'b0; ve[3] = {1'b1, 64'h0};
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i];
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if ({cout, sum} !== ve[i]) begin
                failures++;
                $display("FAIL overflow_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                         i, cout, sum, ve[i][64], ve[i][63:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] q[$];
        logic [64:0] exp;
        for (int i = 0; i < 24; i++) begin
            a   = 64'(i);
            b   = 64'(200 + i);
            cin = (i >= 5 && i < 11) ? i[0] : 1'b0;
            @(posedge clk); #1;
            q.push_back(65'(200 + 2 * i) + 65'(cin));
            if (q.size() == 4) begin
                exp = q.pop_front();
                checks++;
                if ({cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL stream_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                             i, cout, sum, exp[64], exp[63:0]);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 3; i++) begin
            a = 64'h1234_0000_0000_0000 + 64'(i); b = 64'hFFFF; cin = 1'b1;
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout, sum} !== 65'd0) begin
            failures++;
            $display("FAIL reset_async: got cout=%b sum=%h want 0", cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if ({cout, sum} !== 65'd0) begin
            failures++;
            $display("FAIL reset_held: got cout=%b sum=%h want 0", cout, sum);
        end
        rst = 1'b0;
        a = 64'd5; b = 64'd7; cin = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({cout, sum} !== 65'd0) begin
                failures++;
                $display("FAIL reset_flush_%0d: got cout=%b sum=%h want 0", e, cout, sum);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({cout, sum} !== 65'd13) begin
            failures++;
            $display("FAIL reset_first: got cout=%b sum=%h want sum=d", cout, sum);
        end
    endtask

    task automatic test_random();
        logic [64:0] q[$];
        logic [64:0] exp;
        for (int i = 0; i < 10000; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            q.push_back({1'b0, a} + {1'b0, b} + 65'(cin));
            if (q.size() == 4) begin
                exp = q.pop_front();
                checks++;
                if ({cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL random_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                             i, cout, sum, exp[64], exp[63:0]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
